// File: rtl/bin_line_store.sv
// bin_line_store: packs an ASCII stream of binary lines into words, then serves 1-cycle-latency reads
module bin_line_store #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             loaded,
  output logic [AW:0]      count,
  output logic             error,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] data,
  output logic             valid
);
  typedef enum logic {LOAD, READY} state_t;
  localparam int NB = $clog2(WIDTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [NB-1:0] FULL = NB'(WIDTH);
  localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);
  state_t state, state_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] line, line_a, wline;
  logic [NB-1:0] nbits, nbits_a;
  logic take, is_bit, bad, commit, full, store;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= LOAD;
    else state <= state_n;
  always_comb state_n = (state == LOAD && in_valid && in_last) ? READY : state;
  always_comb loaded = state == READY;
  // Decode one byte, then fold in the in_last flush of a complete unterminated line
  always_comb begin
    take = state == LOAD && in_valid;
    is_bit = in_byte == 8'h30 || in_byte == 8'h31;
    line_a = line;
    nbits_a = nbits;
    wline = line;
    bad = 1'b0;
    commit = 1'b0;
    if (is_bit) begin
      if (nbits == FULL) bad = 1'b1;
      else begin
        line_a = {line[WIDTH-2:0], in_byte[0]};
        nbits_a = nbits + 1'b1;
      end
    end else if (in_byte == 8'h0A) begin
      commit = nbits == FULL;
      bad = nbits != '0 && nbits != FULL;
      line_a = '0;
      nbits_a = '0;
    end else if (in_byte != 8'h0D) bad = 1'b1;
    if (in_last) begin
      if (nbits_a == FULL) begin
        commit = 1'b1;
        wline = line_a;
      end else if (nbits_a != '0) bad = 1'b1;
    end
    full = count == CAP;
    store = take && commit && !full;
  end
  always_ff @(posedge clk)
    if (store) mem[count[IW-1:0]] <= wline;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      line <= '0;
      nbits <= '0;
      count <= '0;
      error <= 1'b0;
      data <= '0;
      valid <= 1'b0;
    end else begin
      if (take) begin
        line <= line_a;
        nbits <= nbits_a;
        if (bad || (commit && full)) error <= 1'b1;
      end
      if (store) count <= count + 1'b1;
      valid <= loaded && re;
      if (loaded && re) data <= ({1'b0, addr} < count) ? mem[addr[IW-1:0]] : '0;
    end
endmodule
